// File: rtl/siso_shift_ctrl.sv
// siso_shift_ctrl: serializes a word into the shift chain, then reads it back, returns it and flags mismatches
module siso_shift_ctrl #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int LSB_FIRST   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       sr_d,
    output logic                       sr_en,
    input  logic [WIDTH-1:0]           sr_q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       err,
    input  logic                       err_clr
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, OUT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow, rev_in, rev_sh, ord_in, ord_sh, expected;
    logic [CW-1:0]    nxt;
    logic [HW-1:0]    hold_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign rev_in[i] = in_data[WIDTH-1-i];
        assign rev_sh[i] = shadow[WIDTH-1-i];
    end

    // ord_* hold the bits in transmit order, so bit k of the word goes out on shift k
    assign ord_in   = LSB_FIRST != 0 ? in_data : rev_in;
    assign ord_sh   = LSB_FIRST != 0 ? shadow : rev_sh;
    // the first bit shifted lands in the last stage, so MSB-first reads back unchanged
    assign expected = LSB_FIRST != 0 ? rev_sh : shadow;
    assign nxt      = bit_cnt + 1'b1;

    // sequencing FSM; every output is registered and prepared one cycle ahead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            sr_d      <= 1'b0;
            sr_en     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            err       <= 1'b0;
            shadow    <= '0;
            hold_cnt  <= '0;
        end else begin
            err <= err & ~err_clr;
            case (state)
                IDLE: if (in_valid) begin
                    shadow   <= in_data;
                    bit_cnt  <= '0;
                    sr_en    <= 1'b1;
                    sr_d     <= ord_in[0];
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    bit_cnt <= nxt;
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        sr_en    <= 1'b0;
                        sr_d     <= 1'b0;
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end else begin
                        sr_d <= ord_sh[nxt[IW-1:0]];
                    end
                end
                HOLD: if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    out_data  <= sr_q;
                    out_valid <= 1'b1;
                    if (sr_q != expected) err <= 1'b1;
                    state     <= OUT;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    bit_cnt   <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_siso_shift_ctrl.sv
// tb_siso_shift_ctrl: drives MSB-first and LSB-first controllers side by side against a behavioural chain and word model
module tb_siso_shift_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
    logic [7:0] in_data = '0;
    logic       force_en = 1'b0;
    logic [7:0] force_val = '0;
    logic       in_ready0, sr_d0, sr_en0, out_valid0, busy0, err0;
    logic       in_ready1, sr_d1, sr_en1, out_valid1, busy1, err1;
    logic [7:0] sr_q0, sr_q1, out_data0, out_data1, chain0 = '0, chain1 = '0;
    logic [3:0] bit_cnt0, bit_cnt1;
    logic       err_exp0 = 1'b0;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    siso_shift_ctrl #(.WIDTH(8), .HOLD_CYCLES(2), .LSB_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .sr_d(sr_d0), .sr_en(sr_en0), .sr_q(sr_q0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .busy(busy0), .bit_cnt(bit_cnt0), .err(err0), .err_clr(err_clr));

    siso_shift_ctrl #(.WIDTH(8), .HOLD_CYCLES(2), .LSB_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .sr_d(sr_d1), .sr_en(sr_en1), .sr_q(sr_q1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .busy(busy1), .bit_cnt(bit_cnt1), .err(err1), .err_clr(err_clr));

    // behavioural shift chains: stage 0 takes sr_d, every stage moves up one on an enabled edge
    always @(posedge clk) begin
        if (sr_en0) chain0 <= {chain0[6:0], sr_d0};
        if (sr_en1) chain1 <= {chain1[6:0], sr_d1};
    end
    assign sr_q0 = force_en ? force_val : chain0;
    assign sr_q1 = chain1;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({in_ready0, sr_d0, sr_en0, out_valid0, busy0, err0} !== 6'b100000) begin errors++; $display("FAIL reset_flags0 got %b exp 100000", {in_ready0, sr_d0, sr_en0, out_valid0, busy0, err0}); end
        checks++; if ({in_ready1, sr_d1, sr_en1, out_valid1, busy1, err1} !== 6'b100000) begin errors++; $display("FAIL reset_flags1 got %b exp 100000", {in_ready1, sr_d1, sr_en1, out_valid1, busy1, err1}); end
        checks++; if ({out_data0, out_data1, bit_cnt0, bit_cnt1} !== 24'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {out_data0, out_data1, bit_cnt0, bit_cnt1}); end
        rst_n = 1'b1;
        err_exp0 = 1'b0;
    endtask

    // one full word: accept, WIDTH shifts, HOLD gap, OUT with optional stall and err_clr at the capture edge
    task automatic test_word(input logic [7:0] d, input int stall, input logic frc, input logic [7:0] fval, input logic clr_cap);
        logic [7:0] exp0;
        @(negedge clk);
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL accept_ready d=%h got %b exp 1", d, in_ready0); end
        in_valid = 1'b1; in_data = d; force_en = frc; force_val = fval;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            checks++; if ({sr_en0, sr_en1, busy0, in_ready0} !== 4'b1110) begin errors++; $display("FAIL shift_ctl d=%h k=%0d got %b exp 1110", d, k, {sr_en0, sr_en1, busy0, in_ready0}); end
            checks++; if ({sr_d0, sr_d1} !== {d[7-k], d[k]}) begin errors++; $display("FAIL shift_bits d=%h k=%0d got %b exp %b", d, k, {sr_d0, sr_d1}, {d[7-k], d[k]}); end
            checks++; if (bit_cnt0 !== 4'(k)) begin errors++; $display("FAIL shift_cnt d=%h got %0d exp %0d", d, bit_cnt0, k); end
            @(negedge clk);
        end
        for (int h = 0; h < 2; h++) begin
            if (clr_cap && h == 1) err_clr = 1'b1;
            checks++; if ({sr_en0, sr_d0, sr_en1, out_valid0, out_valid1, busy0} !== 6'b000001) begin errors++; $display("FAIL hold_ctl d=%h h=%0d got %b exp 000001", d, h, {sr_en0, sr_d0, sr_en1, out_valid0, out_valid1, busy0}); end
            checks++; if (bit_cnt0 !== 4'd8) begin errors++; $display("FAIL hold_cnt d=%h got %0d exp 8", d, bit_cnt0); end
            @(negedge clk);
        end
        err_clr = 1'b0;
        exp0 = frc ? fval : d;
        err_exp0 = (exp0 != d) | (err_exp0 & ~clr_cap);
        checks++; if ({out_valid0, out_valid1} !== 2'b11) begin errors++; $display("FAIL out_valid d=%h got %b exp 11", d, {out_valid0, out_valid1}); end
        checks++; if (out_data0 !== exp0) begin errors++; $display("FAIL out_data0 got %h exp %h", out_data0, exp0); end
        checks++; if (out_data1 !== rev8(d)) begin errors++; $display("FAIL out_data1 got %h exp %h", out_data1, rev8(d)); end
        checks++; if ({err0, err1} !== {err_exp0, 1'b0}) begin errors++; $display("FAIL err d=%h got %b exp %b", d, {err0, err1}, {err_exp0, 1'b0}); end
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            @(negedge clk);
            checks++; if ({out_valid0, in_ready0, sr_en0, out_valid1} !== 4'b1001) begin errors++; $display("FAIL stall_ctl s=%0d got %b exp 1001", s, {out_valid0, in_ready0, sr_en0, out_valid1}); end
            checks++; if (out_data0 !== exp0) begin errors++; $display("FAIL stall_data s=%0d got %h exp %h", s, out_data0, exp0); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; force_en = 1'b0;
        checks++; if ({out_valid0, in_ready0, busy0, in_ready1} !== 4'b0101) begin errors++; $display("FAIL release got %b exp 0101", {out_valid0, in_ready0, busy0, in_ready1}); end
        checks++; if (bit_cnt0 !== 4'd0) begin errors++; $display("FAIL release_cnt got %0d exp 0", bit_cnt0); end
    endtask

    task automatic test_back_to_back();
        int acc[2] = '{0, 0};
        logic [7:0] outs[2] = '{8'h11, 8'h11};
        int n = 0, nout = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 1) in_data = 8'h00;
            if (n == 2) in_valid = 1'b0;
            if (in_ready0 && in_valid && n < 2) begin acc[n] = c; n++; end
            if (out_valid0 && nout < 2) begin outs[nout] = out_data0; nout++; end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (n !== 2 || acc[1] - acc[0] !== 12) begin errors++; $display("FAIL b2b_period got %0d accepts spacing %0d exp 2 spacing 12", n, acc[1] - acc[0]); end
        checks++; if (nout !== 2 || outs[0] !== 8'hFF || outs[1] !== 8'h00) begin errors++; $display("FAIL b2b_data got %0d words %h %h exp ff 00", nout, outs[0], outs[1]); end
    endtask

    task automatic test_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        err_exp0 = 1'b0;
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_clr got %b exp 0", err0); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hE7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({sr_en0, busy0, out_valid0, in_ready0, sr_en1, busy1} !== 6'b000100) begin errors++; $display("FAIL mid_reset got %b exp 000100", {sr_en0, busy0, out_valid0, in_ready0, sr_en1, busy1}); end
        err_exp0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if ({out_valid0, out_valid1} !== 2'b00) begin errors++; $display("FAIL mid_reset_valid c=%0d got %b exp 00", c, {out_valid0, out_valid1}); end
        end
        rst_n = 1'b1;
        test_word(8'h5A, 0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_word(8'hA5, 0, 1'b0, 8'h00, 1'b0);
        test_word(8'h01, 0, 1'b0, 8'h00, 1'b0);
        test_back_to_back();
        test_word(8'h96, 20, 1'b0, 8'h00, 1'b0);
        test_word(8'hC3, 0, 1'b1, 8'h3C, 1'b0);
        test_word(8'h4B, 0, 1'b0, 8'h00, 1'b0);
        test_err_clr();
        test_word(8'h77, 0, 1'b1, 8'h70, 1'b1);
        test_err_clr();
        for (int r = 0; r < 8; r++)
            test_word(8'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 1) == 1);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/siso_shift_ctrl.md
# siso_shift_ctrl

Sequencing controller for the 8-stage serial-in/serial-out shift chain. It accepts parallel words over a valid/ready handshake and drives the chain's serial input and shift enable for exactly WIDTH cycles. It then waits a settle gap, reads the chain's parallel taps back, and returns them over a second handshake. The controller also compares the read-back value against the expected value and records any mismatch in a sticky error flag.

## Interface
- WIDTH, 8: chain length in stages; also the word width. Legal range is 2..32.
- HOLD_CYCLES, 2: idle cycles after the last shift, before the taps are sampled. Minimum 1.
- LSB_FIRST, 0: 0 = in_data[WIDTH-1] is shifted first; 1 = in_data[0] is shifted first.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  word offered.
- in_ready  out  1  controller can accept a word.
- in_data  in  WIDTH  word to serialize.
- sr_d  out  1  serial data to chain stage 0.
- sr_en  out  1  shift enable for every chain stage.
- sr_q  in  WIDTH  parallel taps of the chain (Q[0]..Q[WIDTH-1]).
- out_valid  out  1  read-back word available.
- out_ready  in  1  consumer accepts the read-back word.
- out_data  out  WIDTH  sampled sr_q.
- busy  out  1  high in every state except IDLE.
- bit_cnt  out  $clog2(WIDTH+1)  number of bits shifted in the current word.
- err  out  1  sticky flag: a read-back did not match the expected value.
- err_clr  in  1  synchronous clear for err.

## Operation
- States: IDLE, SHIFT, HOLD, OUT.
- IDLE
  - in_ready=1.
  - When in_valid is high, latch in_data into the shadow register, set bit_cnt=0 and move to SHIFT.
- SHIFT
  - sr_en=1.
  - sr_d = shadow[WIDTH-1-bit_cnt] when LSB_FIRST=0; shadow[bit_cnt] when LSB_FIRST=1.
  - bit_cnt increments each cycle.
  - On the cycle with bit_cnt==WIDTH-1: next state is HOLD, and bit_cnt becomes WIDTH.
- HOLD
  - sr_en=0 and sr_d=0.
  - The gap counter runs HOLD_CYCLES cycles.
  - On the last HOLD cycle, register sr_q into out_data and move to OUT.
- OUT
  - out_valid=1; out_data is stable.
  - When out_ready is high: return to IDLE and clear bit_cnt.
  - The next word can only be accepted on the following cycle; there is no same-cycle turnaround.
- Expected value: shadow when LSB_FIRST=0; bit-reversed shadow when LSB_FIRST=1.
  - Compared with sr_q at the out_data capture.
  - On mismatch, err is set.
- err behaviour
  - err_clr clears err.
  - If err_clr and a mismatch occur in the same cycle, set wins.
- in_valid outside IDLE is ignored; in_ready=0 there, so no word is dropped silently.
- Ports are registered; no combinational path exists from any input to any output.

## Timing
- Reset values: state=IDLE, in_ready=1, sr_d=0, sr_en=0, out_valid=0, out_data=0, busy=0, bit_cnt=0, err=0, shadow=0.
- Reset asserted mid-operation:
  - All state is cleared immediately (asynchronous).
  - sr_en drops without waiting for a clock edge.
  - A partially shifted word is abandoned and no out_valid is produced.
  - After reset releases, the first accept can happen on the first rising edge.
- Accept at edge A (in_valid=1 and in_ready=1):
  - sr_en is high for cycles A+1 .. A+WIDTH, exactly WIDTH cycles.
  - The chain receives its last shift at edge A+WIDTH.
- HOLD occupies cycles A+WIDTH+1 .. A+WIDTH+HOLD_CYCLES.
- out_valid rises after edge A+WIDTH+HOLD_CYCLES.
- Minimum word period with out_ready held high: WIDTH+HOLD_CYCLES+2 cycles.
- out_ready low holds OUT indefinitely, with out_data and out_valid unchanged.
- bit_cnt wrap-around: saturates at WIDTH in HOLD and OUT; it never wraps.

## Test plan
- Reset, then one word, WIDTH=8, LSB_FIRST=0, in_data=8'hA5 -> sr_d sequence 1,0,1,0,0,1,0,1 with sr_en high for exactly 8 cycles; out_data=8'hA5; err=0.
- LSB_FIRST=1, in_data=8'h01 -> sr_d high only in the first SHIFT cycle; out_data=8'h80; err=0.
- Back-to-back words 8'hFF then 8'h00 with in_valid held high and out_ready=1 -> second accept 12 cycles after the first; out_data sequence FF then 00.
- out_ready held low for 20 cycles in OUT -> out_valid stays 1 and out_data stays stable; in_ready=0 throughout; sr_en stays 0.
- Bench forces sr_q to 8'h3C while 8'hC3 is being sent -> err=1 after the capture. err stays set across the next good word. err_clr pulse -> err=0.
- reset asserted on the 4th SHIFT cycle -> sr_en=0 and busy=0 immediately, with no out_valid. After release, a new word 8'h5A completes normally.
